// File: rtl/bcd_digit_source_if.sv
// Bundle between a frame-synchronised BCD digit source and its pixel-side consumer.
// The master drives the frame strobe, sampled value and digit index; the slave returns digits and status.
interface bcd_digit_source_if #(
    parameter int BIN_W = 16
);
    logic             vsync;
    logic [BIN_W-1:0] value;
    logic [2:0]       digit_sel;
    logic [3:0]       digit;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output vsync, value, digit_sel,
        input  digit, busy, done, ovf
    );

    modport slave (
        input  vsync, value, digit_sel,
        output digit, busy, done, ovf
    );
endinterface

// File: rtl/bcd_digit_source.sv
// Samples a binary value at each vsync falling edge and converts it serially with shift-add-3.
// The display register is replaced in a single cycle, and digits are read out through a combinational port.
module bcd_digit_source #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5,
    parameter int LZB    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_digit_source_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t             state_reg, state_next;
    logic               prev_vsync_reg;
    logic [BIN_W-1:0]   bin_reg, bin_next;
    logic [BCD_W-1:0]   bcd_reg, bcd_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               ovf_work_reg, ovf_work_next;
    logic [BCD_W-1:0]   display_reg, display_next;
    logic               ovf_reg, ovf_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic               fall;
    logic [BCD_W-1:0]   bcd_adj;
    logic               top_carry;
    logic [DIGITS-1:0]  upper_nz;
    logic [3:0]         digit_w;

    assign fall = prev_vsync_reg & ~bus.vsync;

    // Add-3 is applied to every nibble before the shift; nibbles stay independent.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                    bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end

    assign top_carry = (bcd_reg[BCD_W-1 -: 4] >= 4'd13);

    // upper_nz[i] is set when digit i or any more significant digit is non-zero.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nz
        if (gi == DIGITS - 1) begin : g_top
            assign upper_nz[gi] = |display_reg[gi*4 +: 4];
        end else begin : g_rest
            assign upper_nz[gi] = (|display_reg[gi*4 +: 4]) | upper_nz[gi+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            prev_vsync_reg <= 1'b1;
            bin_reg        <= '0;
            bcd_reg        <= '0;
            count_reg      <= '0;
            ovf_work_reg   <= 1'b0;
            display_reg    <= '0;
            ovf_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            prev_vsync_reg <= bus.vsync;
            bin_reg        <= bin_next;
            bcd_reg        <= bcd_next;
            count_reg      <= count_next;
            ovf_work_reg   <= ovf_work_next;
            display_reg    <= display_next;
            ovf_reg        <= ovf_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bin_next      = bin_reg;
        bcd_next      = bcd_reg;
        count_next    = count_reg;
        ovf_work_next = ovf_work_reg;
        display_next  = display_reg;
        ovf_next      = ovf_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fall) begin
                    state_next    = CONV;
                    bin_next      = bus.value;
                    bcd_next      = '0;
                    count_next    = '0;
                    ovf_work_next = 1'b0;
                    busy_next     = 1'b1;
                end
            end
            CONV: begin
                bcd_next   = {bcd_adj[BCD_W-2:0], bin_reg[BIN_W-1]};
                bin_next   = bin_reg << 1;
                count_next = count_reg + CNT_W'(1);
                // Anything leaving the top nibble is a digit we cannot hold.
                if (bcd_adj[BCD_W-1] || top_carry) begin
                    ovf_work_next = 1'b1;
                end
                if (count_reg == LAST_CNT) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                end
            end
            DONE: begin
                display_next = bcd_reg;
                ovf_next     = ovf_work_reg;
                done_next    = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        digit_w = 4'hF;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.digit_sel == 3'(i)) begin
                if (LZB != 0 && i > 0 && !upper_nz[i]) begin
                    digit_w = 4'hF;
                end else begin
                    digit_w = display_reg[i*4 +: 4];
                end
            end
        end
    end

    assign bus.digit = digit_w;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.ovf   = ovf_reg;
endmodule

// File: tb/tb_bcd_digit_source.sv
// Bench for bcd_digit_source: three builds (5 digits with blanking, 5 digits without, 4 digits with blanking)
// share one stimulus stream and are checked against a decimal-arithmetic reference model.
module tb_bcd_digit_source;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b1;
    logic [15:0] value = '0;
    logic [2:0]  digit_sel = '0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    bcd_digit_source_if #(.BIN_W(16)) bus_a ();
    bcd_digit_source_if #(.BIN_W(16)) bus_b ();
    bcd_digit_source_if #(.BIN_W(16)) bus_c ();

    assign bus_a.vsync = vsync;  assign bus_a.value = value;  assign bus_a.digit_sel = digit_sel;
    assign bus_b.vsync = vsync;  assign bus_b.value = value;  assign bus_b.digit_sel = digit_sel;
    assign bus_c.vsync = vsync;  assign bus_c.value = value;  assign bus_c.digit_sel = digit_sel;

    bcd_digit_source #(.BIN_W(16), .DIGITS(5), .LZB(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    bcd_digit_source #(.BIN_W(16), .DIGITS(5), .LZB(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
    bcd_digit_source #(.BIN_W(16), .DIGITS(4), .LZB(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

    logic [3:0] dig_w  [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       ovf_w  [3];

    assign dig_w[0] = bus_a.digit;  assign busy_w[0] = bus_a.busy;  assign done_w[0] = bus_a.done;  assign ovf_w[0] = bus_a.ovf;
    assign dig_w[1] = bus_b.digit;  assign busy_w[1] = bus_b.busy;  assign done_w[1] = bus_b.done;  assign ovf_w[1] = bus_b.ovf;
    assign dig_w[2] = bus_c.digit;  assign busy_w[2] = bus_c.busy;  assign done_w[2] = bus_c.done;  assign ovf_w[2] = bus_c.ovf;

    // Reference model: plain decimal arithmetic on the sampled value.
    function automatic int ndig(input int u);
        return (u == 2) ? 4 : 5;
    endfunction

    function automatic bit lzb_of(input int u);
        return (u == 1) ? 1'b0 : 1'b1;
    endfunction

    function automatic int unsigned pow10(input int n);
        int unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [3:0] exp_digit(input int unsigned v, input int u, input int sel);
        int unsigned vm;
        if (sel >= ndig(u)) return 4'hF;
        vm = v % pow10(ndig(u));
        if (lzb_of(u) && sel > 0 && (vm / pow10(sel)) == 0) return 4'hF;
        return 4'((vm / pow10(sel)) % 10);
    endfunction

    function automatic logic exp_ovf(input int unsigned v, input int u);
        return (v >= pow10(ndig(u)));
    endfunction

    // One accepted frame: vsync low for three cycles, then the value is scrambled.
    task automatic run_frame(input int unsigned v, output bit ok);
        @(negedge clk);
        value = 16'(v);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        value = 16'($urandom);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk); #1;
            if (done_w[0] === 1'b1) ok = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            total_cnt++;
            if ({busy_w[u], done_w[u], ovf_w[u]} !== 3'b000)
                $display("FAIL reset_status u%0d got busy/done/ovf=%b%b%b exp 000", u, busy_w[u], done_w[u], ovf_w[u]);
            else pass_cnt++;
        end
        for (int s = 0; s < 8; s++) begin
            digit_sel = 3'(s); #1;
            for (int u = 0; u < 3; u++) begin
                total_cnt++;
                if (dig_w[u] !== exp_digit(0, u, s))
                    $display("FAIL reset_digit u%0d sel%0d got %h exp %h", u, s, dig_w[u], exp_digit(0, u, s));
                else pass_cnt++;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int busy_cnt = 0;
        int done_at = -1;
        int done_cnt = 0;
        @(negedge clk);
        value = 16'd12345;
        vsync = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < 30; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            if (n == 2) begin vsync = 1'b1; value = 16'd777; end
            if (busy_w[0] === 1'b1) busy_cnt++;
            if (done_w[0] === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
        end
        total_cnt++;
        if (busy_cnt != 16) $display("FAIL basic_busy_len got %0d exp 16", busy_cnt); else pass_cnt++;
        total_cnt++;
        if (done_at != 17) $display("FAIL basic_done_time got %0d exp 17", done_at); else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1) $display("FAIL basic_done_width got %0d exp 1", done_cnt); else pass_cnt++;
        @(negedge clk);
        for (int s = 0; s < 8; s++) begin
            digit_sel = 3'(s); #1;
            for (int u = 0; u < 3; u++) begin
                total_cnt++;
                if (dig_w[u] !== exp_digit(12345, u, s))
                    $display("FAIL basic_digit u%0d sel%0d got %h exp %h", u, s, dig_w[u], exp_digit(12345, u, s));
                else pass_cnt++;
            end
        end
        for (int u = 0; u < 3; u++) begin
            total_cnt++;
            if (ovf_w[u] !== exp_ovf(12345, u)) $display("FAIL basic_ovf u%0d got %b exp %b", u, ovf_w[u], exp_ovf(12345, u));
            else pass_cnt++;
        end
    endtask

    task automatic test_values(input string name, input int unsigned v);
        bit ok;
        run_frame(v, ok);
        total_cnt++;
        if (!ok) $display("FAIL %s_timeout got no done exp done within 40 cycles", name); else pass_cnt++;
        for (int s = 0; s < 8; s++) begin
            digit_sel = 3'(s); #1;
            for (int u = 0; u < 3; u++) begin
                total_cnt++;
                if (dig_w[u] !== exp_digit(v, u, s))
                    $display("FAIL %s_digit v=%0d u%0d sel%0d got %h exp %h", name, v, u, s, dig_w[u], exp_digit(v, u, s));
                else pass_cnt++;
            end
        end
        for (int u = 0; u < 3; u++) begin
            total_cnt++;
            if (ovf_w[u] !== exp_ovf(v, u)) $display("FAIL %s_ovf v=%0d u%0d got %b exp %b", name, v, u, ovf_w[u], exp_ovf(v, u));
            else pass_cnt++;
        end
        $display("frame %s value=%0d done=%0d", name, v, ok);
    endtask

    task automatic test_back_to_back;
        bit ok = 1'b0;
        int busy_cnt = 0;
        @(negedge clk);
        value = 16'd12345;
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        value = 16'd999;
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        vsync = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk); #1;
            if (done_w[0] === 1'b1) ok = 1'b1;
        end
        total_cnt++;
        if (!ok) $display("FAIL b2b_timeout got no done exp done within 40 cycles"); else pass_cnt++;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (busy_w[0] === 1'b1) busy_cnt++;
        end
        total_cnt++;
        if (busy_cnt != 0) $display("FAIL b2b_no_restart got busy %0d cycles exp 0", busy_cnt); else pass_cnt++;
        @(negedge clk);
        for (int s = 0; s < 8; s++) begin
            digit_sel = 3'(s); #1;
            for (int u = 0; u < 3; u++) begin
                total_cnt++;
                if (dig_w[u] !== exp_digit(12345, u, s))
                    $display("FAIL b2b_digit u%0d sel%0d got %h exp %h", u, s, dig_w[u], exp_digit(12345, u, s));
                else pass_cnt++;
            end
        end
        test_values("b2b_next", 999);
    endtask

    task automatic test_overflow;
        bit ok = 1'b0;
        test_values("ovf_first", 12345);
        @(negedge clk);
        value = 16'd42;
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        total_cnt++;
        if (ovf_w[2] !== 1'b1 || busy_w[2] !== 1'b1)
            $display("FAIL ovf_hold_mid got ovf=%b busy=%b exp ovf=1 busy=1", ovf_w[2], busy_w[2]);
        else pass_cnt++;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk); #1;
            if (done_w[2] === 1'b1) ok = 1'b1;
        end
        total_cnt++;
        if (!ok) $display("FAIL ovf_timeout got no done exp done within 40 cycles"); else pass_cnt++;
        @(negedge clk);
        for (int s = 0; s < 8; s++) begin
            digit_sel = 3'(s); #1;
            for (int u = 0; u < 3; u++) begin
                total_cnt++;
                if (dig_w[u] !== exp_digit(42, u, s))
                    $display("FAIL ovf_digit u%0d sel%0d got %h exp %h", u, s, dig_w[u], exp_digit(42, u, s));
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (ovf_w[2] !== 1'b0) $display("FAIL ovf_clear got %b exp 0", ovf_w[2]); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int done_cnt = 0;
        int busy_cnt = 0;
        test_values("rmid_prior", 12345);
        @(negedge clk);
        value = 16'd54321;
        vsync = 1'b0;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1 vsync = 1'b1;
        rst_n = 1'b0;
        #1;
        for (int u = 0; u < 3; u++) begin
            total_cnt++;
            if ({busy_w[u], done_w[u], ovf_w[u]} !== 3'b000)
                $display("FAIL rmid_status u%0d got busy/done/ovf=%b%b%b exp 000", u, busy_w[u], done_w[u], ovf_w[u]);
            else pass_cnt++;
        end
        for (int s = 0; s < 8; s++) begin
            digit_sel = 3'(s); #1;
            for (int u = 0; u < 3; u++) begin
                total_cnt++;
                if (dig_w[u] !== exp_digit(0, u, s))
                    $display("FAIL rmid_digit u%0d sel%0d got %h exp %h", u, s, dig_w[u], exp_digit(0, u, s));
                else pass_cnt++;
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk); #1;
            if (done_w[0] === 1'b1) done_cnt++;
            if (busy_w[0] === 1'b1) busy_cnt++;
        end
        total_cnt++;
        if (done_cnt != 0 || busy_cnt != 0)
            $display("FAIL rmid_quiet got done=%0d busy=%0d exp 0 0", done_cnt, busy_cnt);
        else pass_cnt++;
        test_values("rmid_after", 12345);
    endtask

    task automatic test_random;
        int unsigned v;
        for (int t = 0; t < 16; t++) begin
            v = (t % 4 == 0) ? $urandom_range(0, 99) : $urandom_range(0, 65535);
            test_values("random", v);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_values("zero", 0);
        test_values("max", 65535);
        test_values("hundred", 100);
        test_back_to_back;
        test_overflow;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end
endmodule
